chirp_uart_tx: RTL and testbench



---
 rtl/chirp_uart_pkg.sv | 26 ++
 rtl/chirp_uart_tx_fifo.sv | 63 ++++++
 rtl/chirp_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_chirp_uart_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chirp_uart_pkg.sv
// Shared definitions for the chirp UART TX/RX pair: frame FSM encoding, bit constants and
// the bit-period computation both directions must agree on.
package chirp_uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Rounded to the nearest whole clock so TX and RX land on the same period.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                                 input int unsigned baud_rate);
        return (clk_freq_hz + baud_rate / 2) / baud_rate;
    endfunction

    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chirp_uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter; registered occupancy count, head word
// visible combinationally on rdata.
module chirp_uart_tx_fifo
    import chirp_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned Depth = 1 << FIFO_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]      mem_q [Depth];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   count_q;
    logic                       do_push;
    logic                       do_pop;

    // The count tops out at exactly Depth, so its MSB alone marks full.
    assign full  = count_q[FIFO_ADDR_WIDTH];
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/chirp_uart_tx.sv
// UART transmitter (8N1, or 8E1 when CHIRP_UART_TX_PARITY_EN is defined) returning status and
// acknowledge bytes to the host; valid/ready byte input buffered by a small FIFO.
module chirp_uart_tx
    import chirp_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 10_000_000,
    parameter int unsigned BAUD_RATE       = 9600,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CntW       = min_width(ClksPerBit);
    localparam int unsigned IdxW       = min_width(DATA_WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
`ifdef CHIRP_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    chirp_uart_tx_fifo #(
        .DATA_WIDTH      (DATA_WIDTH),
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (i_valid),
        .wdata (i_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (cnt_q == CntMax);
    assign o_ready = ~fifo_full;
    assign o_busy  = (state_q != StIdle) | ~fifo_empty;
    assign o_tx    = tx_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef CHIRP_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
`ifdef CHIRP_UART_TX_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxMax) begin
`ifdef CHIRP_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef CHIRP_UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Chain straight into the next start bit so queued frames stay contiguous.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
`ifdef CHIRP_UART_TX_PARITY_EN
                        parity_d = ^fifo_rdata;
`endif
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Line level is derived from the next state so o_tx can come straight from a flop.
        unique case (state_d)
            StStart:  tx_d = START_BIT;
            StData:   tx_d = shift_d[0];
`ifdef CHIRP_UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= STOP_BIT;
`ifdef CHIRP_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef CHIRP_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_chirp_uart_tx.sv
// Directed bench for chirp_uart_tx: default 9600 Bd instance plus a 115200 Bd instance at 50 MHz.
module tb_chirp_uart_tx;

    localparam int CPB   = 1042;
    localparam int S_CPB = 434;
`ifdef CHIRP_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst, valid, ready, tx, busy;
    logic [7:0] data;
    logic       s_rst, s_valid, s_ready, s_tx, s_busy;
    logic [7:0] s_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic       mon_en = 1'b0;
    logic [7:0] mon_byte [$];
    int         mon_start [$];
    logic       mon_ok [$];
    logic       mon_par [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chirp_uart_tx dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    chirp_uart_tx #(
        .CLK_FREQ_HZ (50_000_000),
        .BAUD_RATE   (115200)
    ) dut_fast (
        .i_clk   (clk),
        .i_rst   (s_rst),
        .i_data  (s_data),
        .i_valid (s_valid),
        .o_ready (s_ready),
        .o_tx    (s_tx),
        .o_busy  (s_busy)
    );

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line decoder: samples every bit at its middle, starting from the detected falling edge.
    initial begin : monitor
        int t0;
        logic [7:0] b;
        logic ok, p;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx === 1'b0) begin
                t0 = cyc;
                b  = '0;
                p  = 1'b0;
                wait_ticks(CPB / 2);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    wait_ticks(CPB);
                    b[i] = tx;
                end
`ifdef CHIRP_UART_TX_PARITY_EN
                wait_ticks(CPB);
                p = tx;
`endif
                wait_ticks(CPB);
                ok = ok & (tx === 1'b1);
                mon_byte.push_back(b);
                mon_start.push_back(t0);
                mon_ok.push_back(ok);
                mon_par.push_back(p);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        wait_ticks(3);
        rst = 1'b0; s_rst = 1'b0;
        wait_ticks(1);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b want 1", tx); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests_run++;
        if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_fast: got tx=%b busy=%b ready=%b want 1 0 1", s_tx, s_busy, s_ready);
        end
    endtask

    task automatic test_single_byte();
        logic [10:0] exp_bits;
`ifdef CHIRP_UART_TX_PARITY_EN
        exp_bits = 11'b10010101010;
`else
        exp_bits = 11'b01010101010;
`endif
        data = 8'h55; valid = 1'b1;
        wait_ticks(1);
        valid = 1'b0;
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL single_early: got %b want 1", tx); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_ticks(1);
        tests_run++;
        if (tx !== 1'b0) begin tests_failed++; $display("FAIL single_fall: got %b want 0", tx); end
        wait_ticks(CPB / 2);
        for (int i = 0; i < NBITS; i++) begin
            if (i > 0) wait_ticks(CPB);
            tests_run++;
            if (tx !== exp_bits[i]) begin
                tests_failed++;
                $display("FAIL single_bit%0d: got %b want %b", i, tx, exp_bits[i]);
            end
        end
        wait_ticks(CPB / 2 - 1);
        tests_run++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_stop_end: got busy=%b tx=%b want 1 1", busy, tx);
        end
        wait_ticks(1);
        tests_run++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_idle: got busy=%b tx=%b want 0 1", busy, tx);
        end
    endtask

    task automatic test_param_sweep();
        int t0, n_edges;
        logic prev;
        int rel [8];
        int exp_rel [8];
`ifdef CHIRP_UART_TX_PARITY_EN
        exp_rel = '{0, 434, 1736, 3906, 4774, 5208, 6076, 9114};
`else
        exp_rel = '{0, 434, 1736, 3906, 4340, 4774, 5642, 8246};
`endif
        s_data = 8'h07; s_valid = 1'b1;
        wait_ticks(1);
        s_data = 8'h03;
        wait_ticks(1);
        s_valid = 1'b0;
        tests_run++;
        if (s_tx !== 1'b0) begin tests_failed++; $display("FAIL sweep_fall: got %b want 0", s_tx); end
        t0 = cyc; prev = 1'b0; n_edges = 1;
        for (int i = 0; i < 8; i++) rel[i] = 0;
        repeat (2 * NBITS * S_CPB + 20) begin
            wait_ticks(1);
            if (s_tx !== prev) begin
                if (n_edges < 8) rel[n_edges] = cyc - t0;
                n_edges++;
                prev = s_tx;
            end
        end
        tests_run++;
        if (n_edges != 8) begin
            tests_failed++;
            $display("FAIL sweep_edges: got %0d want 8", n_edges);
        end
        for (int i = 1; i < 8; i++) begin
            tests_run++;
            if (rel[i] != exp_rel[i]) begin
                tests_failed++;
                $display("FAIL sweep_edge%0d: got %0d want %0d", i, rel[i], exp_rel[i]);
            end
        end
        tests_run++;
        if (s_busy !== 1'b0 || s_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep_idle: got busy=%b tx=%b want 0 1", s_busy, s_tx);
        end
    endtask

    task automatic test_back_to_back();
        int e0, guard, n;
        logic [7:0] exp_bytes [6];
        logic       exp_par [6];
        exp_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        exp_par   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        mon_byte.delete(); mon_start.delete(); mon_ok.delete(); mon_par.delete();
        mon_en = 1'b1;
        e0 = cyc;
        data = 8'hA0; valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_ticks(1);
            data = 8'(8'hA0 + k);
            tests_run++;
            if (ready !== (k < 5)) begin
                tests_failed++;
                $display("FAIL b2b_ready_after%0d: got %b want %b", k, ready, (k < 5));
            end
        end
        // i_valid stays high with A5 while the FIFO is full.
        wait_ticks(FL - 4);
        tests_run++;
        if (ready !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_hold: got ready=%b tx=%b want 0 1", ready, tx);
        end
        wait_ticks(1);
        tests_run++;
        if (ready !== 1'b1 || tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame2_start: got ready=%b tx=%b want 1 0", ready, tx);
        end
        wait_ticks(1);
        valid = 1'b0;
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("FAIL refill_full: got %b want 0", ready); end

        guard = 0;
        while (mon_byte.size() < 6 && guard < 6 * FL) begin
            wait_ticks(1);
            guard++;
        end
        tests_run++;
        if (mon_byte.size() != 6) begin
            tests_failed++;
            $display("FAIL b2b_frames: got %0d want 6", mon_byte.size());
            mon_en = 1'b0;
            return;
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (mon_byte[k] !== exp_bytes[k] || mon_ok[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_byte%0d: got %h ok=%b want %h ok=1", k, mon_byte[k], mon_ok[k],
                         exp_bytes[k]);
            end
            tests_run++;
            if (mon_start[k] != e0 + 2 + k * FL) begin
                tests_failed++;
                $display("FAIL b2b_start%0d: got %0d want %0d", k, mon_start[k], e0 + 2 + k * FL);
            end
`ifdef CHIRP_UART_TX_PARITY_EN
            tests_run++;
            if (mon_par[k] !== exp_par[k]) begin
                tests_failed++;
                $display("FAIL b2b_parity%0d: got %b want %b", k, mon_par[k], exp_par[k]);
            end
`endif
        end
        tests_run++;
        if (mon_start[5] + FL - mon_start[0] != 6 * FL) begin
            tests_failed++;
            $display("FAIL b2b_total: got %0d want %0d", mon_start[5] + FL - mon_start[0], 6 * FL);
        end
        n = e0 + 2 + 6 * FL - 1 - cyc;
        if (n > 0) wait_ticks(n);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_end: got %b want 1", busy); end
        wait_ticks(1);
        tests_run++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle: got busy=%b tx=%b want 0 1", busy, tx);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int lows, busies;
        data = 8'hFF; valid = 1'b1;
        wait_ticks(1);
        data = 8'h11; wait_ticks(1);
        data = 8'h22; wait_ticks(1);
        data = 8'h33; wait_ticks(1);
        valid = 1'b0;
        tests_run++;
        if (ready !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_queued: got ready=%b busy=%b want 1 1", ready, busy);
        end
        wait_ticks(4 * CPB + CPB / 2 + 1 - 3);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_bit3: got tx=%b busy=%b want 1 1", tx, busy);
        end
        rst = 1'b1;
        wait_ticks(1);
        tests_run++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_after: got tx=%b ready=%b busy=%b want 1 1 0", tx, ready, busy);
        end
        rst = 1'b0;
        lows = 0; busies = 0;
        repeat (3 * CPB) begin
            wait_ticks(1);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
        tests_run++;
        if (lows != 0 || busies != 0) begin
            tests_failed++;
            $display("FAIL rstmid_quiet: got low=%0d busy=%0d cycles want 0 0", lows, busies);
        end
    endtask

    initial begin
        rst = 1'b1; s_rst = 1'b1;
        valid = 1'b0; data = '0;
        s_valid = 1'b0; s_data = '0;
        test_reset();
        fork
            test_single_byte();
            test_param_sweep();
        join
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
